// File: rtl/send_cmd_dispatcher.sv
// Queues PCIe send requests and issues paced per-MAC send commands.
// Slot LSB picks the port; dispatch is strictly in order.
module send_cmd_dispatcher #(
  parameter logic [24:0] BASE_ADDR  = 25'h0000000,
  parameter int          SLOT_SHIFT = 11,
  parameter int          FIFO_DEPTH = 8,
  parameter int          GAP_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  pcie_send_control_start_ram_addr,
  input  logic        pcie_send_control_signal,
  input  logic        ddr_ready,
  input  logic        mac_inited,
  output logic [24:0] send_packet_1_control_start_ram_addr,
  output logic        send_packet_1_control_cmd_send,
  output logic [24:0] send_packet_2_control_start_ram_addr,
  output logic        send_packet_2_control_cmd_send,
  output logic [3:0]  pending_count,
  output logic        overflow_err,
  output logic [7:0]  drop_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int GW = $clog2(GAP_CYCLES + 1);

  typedef enum logic {IDLE, ISSUE} state_e;

  state_e          state_q, state_d;
  logic            sig_q;
  logic [5:0]      mem_q [FIFO_DEPTH];
  logic [AW-1:0]   rd_q, wr_q;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [GW-1:0]   gap1_q, gap2_q;
  logic            ovf_q;
  logic [7:0]      drop_q;
  logic [24:0]     addr1_q, addr2_q;
  logic            cmd1_q, cmd2_q;

  logic            push, pop, accept, drop;
  logic            empty, full, gap_free;
  logic [5:0]      head;
  logic [24:0]     head_addr;

  assign push      = pcie_send_control_signal & ~sig_q;
  assign empty     = (cnt_q == '0);
  assign full      = (cnt_q == CW'(FIFO_DEPTH));
  assign head      = mem_q[rd_q];
  assign head_addr = BASE_ADDR + (25'(head) << SLOT_SHIFT);
  assign gap_free  = head[0] ? (gap2_q == '0) : (gap1_q == '0);
  // A full queue still takes a request when the head leaves this cycle
  assign accept    = push & (~full | pop);
  assign drop      = push & full & ~pop;
  assign cnt_d     = cnt_q + CW'(accept) - CW'(pop);

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!empty && ddr_ready && mac_inited && gap_free) begin
          pop     = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (accept) mem_q[wr_q] <= pcie_send_control_start_ram_addr;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sig_q   <= 1'b0;
      rd_q    <= '0;
      wr_q    <= '0;
      cnt_q   <= '0;
      gap1_q  <= '0;
      gap2_q  <= '0;
      ovf_q   <= 1'b0;
      drop_q  <= '0;
      addr1_q <= '0;
      addr2_q <= '0;
      cmd1_q  <= 1'b0;
      cmd2_q  <= 1'b0;
    end else begin
      sig_q  <= pcie_send_control_signal;
      cnt_q  <= cnt_d;
      cmd1_q <= pop & ~head[0];
      cmd2_q <= pop & head[0];
      if (accept) wr_q <= wr_q + 1'b1;
      if (pop)    rd_q <= rd_q + 1'b1;
      if (drop) begin
        ovf_q <= 1'b1;
        if (drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
      end
      if (pop && !head[0]) begin
        addr1_q <= head_addr;
        gap1_q  <= GW'(GAP_CYCLES);
      end else if (gap1_q != '0) begin
        gap1_q  <= gap1_q - 1'b1;
      end
      if (pop && head[0]) begin
        addr2_q <= head_addr;
        gap2_q  <= GW'(GAP_CYCLES);
      end else if (gap2_q != '0) begin
        gap2_q  <= gap2_q - 1'b1;
      end
    end
  end

  assign send_packet_1_control_start_ram_addr = addr1_q;
  assign send_packet_1_control_cmd_send       = cmd1_q;
  assign send_packet_2_control_start_ram_addr = addr2_q;
  assign send_packet_2_control_cmd_send       = cmd2_q;
  assign pending_count                        = 4'(cnt_q);
  assign overflow_err                         = ovf_q;
  assign drop_count                           = drop_q;

endmodule

// File: tb/tb_send_cmd_dispatcher.sv
// Scoreboard bench for send_cmd_dispatcher.
// Timing-level reference model predicts every pulse, address and counter.
module tb_send_cmd_dispatcher;

  localparam logic [24:0] BASE  = 25'h1FFF000;
  localparam int          SHIFT = 11;
  localparam int          DEPTH = 8;
  localparam int          G     = 64;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  slot;
  logic        signal;
  logic        ddr_ready;
  logic        mac_inited;
  logic [24:0] a1, a2;
  logic        c1, c2;
  logic [3:0]  pend;
  logic        ovf;
  logic [7:0]  drops;

  always #5 clk = ~clk;

  send_cmd_dispatcher #(
    .BASE_ADDR (BASE),
    .SLOT_SHIFT(SHIFT),
    .FIFO_DEPTH(DEPTH),
    .GAP_CYCLES(G)
  ) dut (
    .clk                                  (clk),
    .reset                                (reset),
    .pcie_send_control_start_ram_addr     (slot),
    .pcie_send_control_signal             (signal),
    .ddr_ready                            (ddr_ready),
    .mac_inited                           (mac_inited),
    .send_packet_1_control_start_ram_addr (a1),
    .send_packet_1_control_cmd_send       (c1),
    .send_packet_2_control_start_ram_addr (a2),
    .send_packet_2_control_cmd_send       (c2),
    .pending_count                        (pend),
    .overflow_err                         (ovf),
    .drop_count                           (drops)
  );

  typedef struct {
    bit          p2;
    logic [24:0] addr;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  logic [5:0]  mq[$];
  int          cyc = 0;
  int          last1 = -1000, last2 = -1000, last_any = -1000;
  bit          sig_prev;
  int          e_pend, e_drop;
  bit          e_ovf;
  logic [24:0] e_a1, e_a2;
  int          checks = 0, passed = 0;
  bit          mon_en = 1'b0;
  bit          m_pop;
  logic [5:0]  m_head;
  logic [24:0] m_addr;
  int          m_last;

  function automatic logic [24:0] addr_of(logic [5:0] s);
    longint v;
    v = longint'(BASE) + longint'(s) * (longint'(1) << SHIFT);
    return 25'(v % (longint'(1) << 25));
  endfunction

  // Reference model: evaluated at each clock edge with the inputs of the ending cycle
  always @(posedge clk) begin
    if (reset) begin
      mq.delete();
      sig_prev = 1'b0;
      last1 = -1000; last2 = -1000; last_any = -1000;
      e_pend = 0; e_drop = 0; e_ovf = 1'b0;
      e_a1 = '0; e_a2 = '0;
    end else begin
      m_pop = 1'b0;
      if (mq.size() > 0 && ddr_ready && mac_inited && last_any != cyc) begin
        m_head = mq[0];
        m_last = m_head[0] ? last2 : last1;
        if ((cyc + 1) - m_last >= G + 1) m_pop = 1'b1;
      end
      if (m_pop) begin
        void'(mq.pop_front());
        m_addr = addr_of(m_head);
        sb.push_back('{m_head[0], m_addr, cyc + 1});
        if (m_head[0]) begin last2 = cyc + 1; e_a2 = m_addr; end
        else begin last1 = cyc + 1; e_a1 = m_addr; end
        last_any = cyc + 1;
      end
      if (signal && !sig_prev) begin
        if (mq.size() < DEPTH) mq.push_back(slot);
        else begin
          e_ovf = 1'b1;
          if (e_drop < 255) e_drop++;
        end
      end
      sig_prev = signal;
      e_pend = mq.size();
    end
    cyc++;
  end

  task automatic chk(string n, int act, int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at cycle %0d", n, act, exp, cyc);
  endtask

  bit x1, x2;
  always @(negedge clk) begin
    if (mon_en) begin
      while (sb.size() > 0 && sb[0].cyc < cyc) begin
        checks++;
        $display("FAIL missed_pulse: port%0d addr %0h never seen, expected at cycle %0d",
                 sb[0].p2 ? 2 : 1, sb[0].addr, sb[0].cyc);
        void'(sb.pop_front());
      end
      x1 = (sb.size() > 0 && sb[0].cyc == cyc && !sb[0].p2);
      x2 = (sb.size() > 0 && sb[0].cyc == cyc && sb[0].p2);
      chk("cmd1", int'(c1), int'(x1));
      chk("cmd2", int'(c2), int'(x2));
      if (x1 || x2) void'(sb.pop_front());
      chk("addr1", int'(a1), int'(e_a1));
      chk("addr2", int'(a2), int'(e_a2));
      chk("pending", int'(pend), e_pend);
      chk("overflow", int'(ovf), int'(e_ovf));
      chk("drops", int'(drops), e_drop);
    end
  end

  task automatic idle(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic req(logic [5:0] s);
    @(negedge clk);
    slot = s; signal = 1'b1;
    @(negedge clk);
    signal = 1'b0;
  endtask

  int hold;
  initial begin
    reset = 1'b1; signal = 1'b0; slot = '0;
    ddr_ready = 1'b1; mac_inited = 1'b1;
    idle(3);
    reset = 1'b0;
    mon_en = 1'b1;
    idle(5);
    req(6'd5); idle(10);
    req(6'd2); req(6'd4); idle(150);
    req(6'd2); req(6'd3); req(6'd4); idle(150);
    ddr_ready = 1'b0;
    repeat (9) req(6'($urandom));
    idle(3);
    ddr_ready = 1'b1;
    idle(600);
    @(negedge clk);
    slot = 6'd7; signal = 1'b1;
    idle(20);
    signal = 1'b0;
    idle(80);
    req(6'd63); idle(80);
    req(6'd0); idle(3);
    mac_inited = 1'b0;
    req(6'd2); req(6'd4); req(6'd6);
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0; mac_inited = 1'b1;
    idle(5);
    req(6'd9); idle(80);
    repeat (300) begin
      @(negedge clk);
      ddr_ready  = ($urandom % 4) != 0;
      mac_inited = ($urandom % 8) != 0;
      slot = 6'($urandom);
      signal = 1'b1;
      hold = $urandom_range(1, 3);
      idle(hold);
      signal = 1'b0;
      idle($urandom % 4);
    end
    ddr_ready = 1'b1; mac_inited = 1'b1;
    for (int i = 0; i < 3000 && (sb.size() > 0 || mq.size() > 0); i++) @(negedge clk);
    idle(2);
    if (sb.size() > 0 || mq.size() > 0) begin
      checks++;
      $display("FAIL drain_timeout: %0d pulses still outstanding, required 0", sb.size() + mq.size());
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
